muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle RV32M multiply/divide execution unit. It sits directly downstream of the register file: it consumes Rs1Data/Rs2Data as operands and produces the value written back through WriteData for M-extension instructions. While an operation is in flight it holds the single-cycle datapath via a stall signal, so the PC and RegWrite are frozen until the result is committed.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- CPU_clk  input  1  clock, rising edge.
- CPU_rst_n  input  1  reset; asynchronous, active-low.
- Start  input  1  level; high while the decoded instruction is M-type (opcode 0110011, funct7 0000001).
- Funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OperandA  input  WIDTH  rs1 value (Rs1Data).
- OperandB  input  WIDTH  rs2 value (Rs2Data).
- Result  output  WIDTH  registered result; valid while Done=1; holds its value otherwise.
- Done  output  1  registered; one-cycle pulse when Result is valid. The CPU writes back and advances the PC in this cycle.
- Busy  output  1  registered; high in every state except IDLE.
- Stall  output  1  combinational, Start & ~Done; gates the PC update and RegWrite.

## Operation
- States:
  - IDLE.
  - MUL: one cycle; computes the product.
  - DIV: WIDTH iterations.
  - DONE: one cycle; drives the Done pulse.
- IDLE:
  - Start=1 captures Funct3, OperandA and OperandB.
  - MUL family (Funct3[2]=0) goes to MUL.
  - Divide with OperandB=0 goes directly to DONE with the special result.
  - Signed divide with OperandA=0x80000000 and OperandB=0xFFFFFFFF goes directly to DONE with the special result.
  - All other divides go to DIV.
- Start is ignored outside IDLE. Operand or Funct3 changes after capture have no effect.
- MUL:
  - Forms a 2·WIDTH-bit product of 33-bit extended operands. rs1 is sign-extended for MULH/MULHSU. rs2 is sign-extended for MULH only.
  - MUL returns the low WIDTH bits. MULH, MULHSU and MULHU return the high WIDTH bits.
  - Result is registered; then go to DONE.
- DIV:
  - Restoring divide on magnitudes. For signed ops, operands are negated if negative at capture.
  - Partial remainder is WIDTH+1 bits; the counter runs WIDTH-1 down to 0. Each cycle: shift {rem, quo} left by 1, trial-subtract the divisor, keep the result if non-negative, and set the quotient LSB.
  - At count 0 the sign is fixed up. The quotient is negated if the operand signs differ (DIV). The remainder takes the dividend's sign (REM).
  - Result is registered; then go to DONE.
- Special results:
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = OperandA.
  - Signed overflow: DIV = 0x80000000; REM = 0.
- DONE: Done=1 for exactly one cycle, then IDLE unconditionally.
  - Back-to-back M instructions: the next Start is sampled in the following IDLE cycle.
- Reset (asynchronous, also mid-operation):
  - state=IDLE, Result=0, Done=0, Busy=0; counter and internal registers are 0.
  - Any in-flight operation is abandoned, with no Done pulse.

## Timing
- Cycle T is the IDLE cycle in which Start=1.
- MUL family: MUL at T+1, Done at T+2. Total 3 cycles; Stall high in T and T+1.
- DIV family (normal): DIV at T+1..T+WIDTH, Done at T+WIDTH+1 (T+33). Stall high in T..T+32.
- Special divide: Done at T+1. Stall high in T only.
- Busy rises at T+1 and falls at the edge ending DONE.
- Stall has no register. It depends combinationally on Start and Done, so the CPU must not use it to form Start.

## Structure
- Shared package muldiv_pkg holds:
  - localparams for the funct3 encodings (F3_MUL … F3_REMU);
  - the state encoding (IDLE, MUL, DIV, DONE, 2 bits);
  - the M-extension funct7 constant 7'b0000001 used by the decoder.
- One sub-module, muldiv_div_core, holds the iterative datapath: remainder/quotient registers, counter and trial subtractor. Its controls are load/step and its status is last.
- The control FSM, the multiplier, the special-case detection and sign fix-up stay in muldiv_unit.
- The multiply is behavioural (*). Synthesis infers DSP blocks.

## Test plan
- Reset: assert CPU_rst_n=0 mid-DIV at iteration 10, then release. Required: Result=0, Done=0, Busy=0; no Done pulse; the next Start is accepted normally.
- Multiply: MUL 0xFFFFFFFF×0xFFFFFFFF gives 0x00000001. MULH same operands gives 0x00000000. MULHU gives 0xFFFFFFFE. MULHSU gives 0xFFFFFFFF. Each has Done exactly at T+2.
- Divide: DIV −7/2 gives 0xFFFFFFFD. REM −7/2 gives 0xFFFFFFFF. DIVU 100/7 gives 14. REMU 100/7 gives 2. Each has Done at T+33, and Stall is high for 33 cycles.
- Divide by zero: DIVU 0x12345678/0 gives 0xFFFFFFFF. REM 0x12345678/0 gives 0x12345678. Done at T+1.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000. REM same operands gives 0. Done at T+1.
- Back-to-back MUL then DIV with Start held high: the second op captures in the IDLE cycle after DONE. Operands changed during Busy do not affect either Result. Exactly one Done pulse per op.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the RV32M multiply/divide unit: funct3 operation
// encodings, the M-extension funct7 value used by the decoder, and the
// control FSM state encoding.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    // funct3 encodings for OP (0110011) with funct7 = 0000001
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // funct7 that marks an M-extension instruction
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// -----------------------------------------------------------------------------
// muldiv_div_core
// Iterative restoring divider on unsigned magnitudes, one quotient bit per
// step. The caller loads magnitudes, then asserts step for WIDTH cycles;
// last is high during the final step. quo_next/rem_next are the values this
// step produces, so the caller can register the final result in the same
// cycle that last is high.
//
// Ports:
//   CPU_clk, CPU_rst_n   clock, asynchronous active-low reset
//   load                 capture dividend/divisor, clear remainder, arm counter
//   step                 perform one shift/trial-subtract iteration
//   dividend, divisor    unsigned magnitudes (sampled on load)
//   quo_next, rem_next   quotient/remainder after the current step
//   last                 counter has reached 0 (final iteration)
// -----------------------------------------------------------------------------
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             CPU_clk,
    input  logic             CPU_rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo_next,
    output logic [WIDTH-1:0] rem_next,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;

    // The partial remainder stays below the divisor, so it fits in WIDTH bits;
    // only the shifted value needs the extra bit for the trial subtract.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign fits     = ~diff[WIDTH];
    assign rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], fits};
    assign last     = (cnt_q == '0);

    always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
        if (!CPU_rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= CW'(WIDTH - 1);
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (!last) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle RV32M multiply/divide unit. Captures the operation on Start in
// IDLE, then: multiplies in one cycle, or divides iteratively (WIDTH cycles),
// or resolves divide-by-zero / signed overflow immediately. Result is held
// until the next operation; Done pulses for one cycle when it is valid.
//
// Handshake: Start is a level from the decoder. It is sampled only in IDLE;
// once captured, operands and Funct3 may change freely. Done is a one-cycle
// pulse in which the CPU writes Result back. Stall = Start & ~Done freezes
// the PC and RegWrite from the Start cycle up to (not including) Done.
//
// Ports:
//   CPU_clk, CPU_rst_n   clock, asynchronous active-low reset
//   Start                decoded instruction is M-type
//   Funct3               operation select
//   OperandA, OperandB   rs1 / rs2 values
//   Result               registered result, valid while Done
//   Done                 one-cycle completion pulse
//   Busy                 high in every state except IDLE
//   Stall                combinational datapath hold
//   DbgState             current FSM state
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CPU_clk,
    input  logic             CPU_rst_n,
    input  logic             Start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             Busy,
    output logic             Stall,
    output state_t           DbgState
);

    state_t           state;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             quo_neg_q;
    logic             rem_neg_q;

    // ---------------- capture-time decode ----------------
    logic             signed_div;
    logic             a_neg;
    logic             b_neg;
    logic             div_by_zero;
    logic             div_overflow;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic             div_load;
    logic             div_step;

    // funct3[0]=0 selects the signed DIV/REM variants
    assign signed_div   = ~Funct3[0];
    assign a_neg        = signed_div & OperandA[WIDTH-1];
    assign b_neg        = signed_div & OperandB[WIDTH-1];
    assign div_by_zero  = (OperandB == '0);
    assign div_overflow = signed_div && (OperandA == {1'b1, {(WIDTH-1){1'b0}}})
                          && (OperandB == '1);
    assign dividend_mag = a_neg ? -OperandA : OperandA;
    assign divisor_mag  = b_neg ? -OperandB : OperandB;
    assign div_load     = (state == IDLE) && Start && Funct3[2]
                          && !div_by_zero && !div_overflow;
    assign div_step     = (state == DIV);

    // ---------------- multiplier ----------------
    // Extending to 2*WIDTH and truncating the product is equivalent to the
    // 33-bit extended multiply for the bits we keep.
    logic                      mul_a_sign;
    logic                      mul_b_sign;
    logic signed [2*WIDTH-1:0] mul_a;
    logic signed [2*WIDTH-1:0] mul_b;
    logic signed [2*WIDTH-1:0] product;

    assign mul_a_sign = ((f3_q == F3_MULH) || (f3_q == F3_MULHSU)) & a_q[WIDTH-1];
    assign mul_b_sign = (f3_q == F3_MULH) & b_q[WIDTH-1];
    assign mul_a      = {{WIDTH{mul_a_sign}}, a_q};
    assign mul_b      = {{WIDTH{mul_b_sign}}, b_q};
    assign product    = mul_a * mul_b;

    // ---------------- divider ----------------
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] rem_next;
    logic             div_last;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
        .CPU_clk   (CPU_clk),
        .CPU_rst_n (CPU_rst_n),
        .load      (div_load),
        .step      (div_step),
        .dividend  (dividend_mag),
        .divisor   (divisor_mag),
        .quo_next  (quo_next),
        .rem_next  (rem_next),
        .last      (div_last)
    );

    // quotient negative when operand signs differ; remainder follows dividend
    assign quo_fixed = quo_neg_q ? -quo_next : quo_next;
    assign rem_fixed = rem_neg_q ? -rem_next : rem_next;

    // ---------------- control FSM ----------------
    always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
        if (!CPU_rst_n) begin
            state     <= IDLE;
            f3_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            Result    <= '0;
            Done      <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        f3_q      <= Funct3;
                        a_q       <= OperandA;
                        b_q       <= OperandB;
                        quo_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        Busy      <= 1'b1;
                        if (!Funct3[2]) begin
                            state <= MUL;
                        end else if (div_by_zero) begin
                            // funct3[1]=1 selects REM/REMU
                            Result <= Funct3[1] ? OperandA : '1;
                            Done   <= 1'b1;
                            state  <= DONE;
                        end else if (div_overflow) begin
                            Result <= Funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
                            Done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= DIV;
                        end
                    end
                end
                MUL: begin
                    Result <= (f3_q == F3_MUL) ? product[WIDTH-1:0]
                                               : product[2*WIDTH-1:WIDTH];
                    Done   <= 1'b1;
                    state  <= DONE;
                end
                DIV: begin
                    if (div_last) begin
                        Result <= f3_q[1] ? rem_fixed : quo_fixed;
                        Done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Stall    = Start & ~Done;
    assign DbgState = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed and random stimulus for muldiv_unit. Expected results are queued
// when an operation is driven and popped when Done is seen.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        CPU_clk;
    logic        CPU_rst_n;
    logic        Start;
    logic [2:0]  Funct3;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic [31:0] Result;
    logic        Done;
    logic        Busy;
    logic        Stall;
    state_t      dbg_state;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .CPU_clk   (CPU_clk),
        .CPU_rst_n (CPU_rst_n),
        .Start     (Start),
        .Funct3    (Funct3),
        .OperandA  (OperandA),
        .OperandB  (OperandB),
        .Result    (Result),
        .Done      (Done),
        .Busy      (Busy),
        .Stall     (Stall),
        .DbgState  (dbg_state)
    );

    // ---------------- clock ----------------
    initial CPU_clk = 1'b0;
    always #5 CPU_clk = ~CPU_clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference model built from native SV arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f3)
            F3_MUL:    begin p = ua * ub; return p[31:0];  end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM:    begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return $signed(a) % $signed(b);
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // ---------------- driver ----------------
    // Drives one operation in the current IDLE cycle (at its negedge), then
    // scrambles the inputs while busy. With hold=1 Start stays high so the
    // next call captures in the IDLE cycle right after DONE.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit hold);
        int k = 0;
        int stall_cycles = 0;
        bit got = 0;
        @(negedge CPU_clk);
        Start    = 1'b1;
        Funct3   = f3;
        OperandA = a;
        OperandB = b;
        exp_q.push_back(exp);
        #1;
        if (Stall) stall_cycles++;
        while (!got && k < 100) begin
            @(posedge CPU_clk);
            #1;
            k++;
            if (k == 1) check({tag, "_busy"}, 32'(Busy), 32'd1);
            if (Done) begin
                got = 1;
            end else begin
                if (Stall) stall_cycles++;
                Funct3   = 3'($urandom_range(0, 7));
                OperandA = $urandom;
                OperandB = $urandom;
            end
        end
        check({tag, "_latency"}, 32'(k), 32'(lat));
        if (got) begin
            check({tag, "_result"}, Result, exp_q.pop_front());
            check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(lat));
        end else begin
            void'(exp_q.pop_front());
        end
        @(negedge CPU_clk);
        if (hold) begin
            OperandA = $urandom;
            OperandB = $urandom;
        end else begin
            Start = 1'b0;
        end
        @(posedge CPU_clk);
        #1;
        check({tag, "_done_pulse_once"}, 32'(Done), 32'd0);
        check({tag, "_busy_after"}, 32'(Busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra, rb;
        int          done_seen;

        CPU_rst_n = 1'b0;
        Start     = 1'b0;
        Funct3    = '0;
        OperandA  = '0;
        OperandB  = '0;
        repeat (3) @(posedge CPU_clk);
        #1;
        check("reset_result", Result, 32'h0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_stall", 32'(Stall), 32'd0);
        @(negedge CPU_clk);
        CPU_rst_n = 1'b1;

        // multiply family
        run_op("mul",    F3_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2, 0);
        run_op("mulh",   F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2, 0);
        run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0);
        run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 0);

        // divide family
        run_op("div",  F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("rem",  F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("divu", F3_DIVU, 32'd100,       32'd7, 32'd14,        33, 0);
        run_op("remu", F3_REMU, 32'd100,       32'd7, 32'd2,         33, 0);

        // divide by zero and signed overflow
        run_op("divu_zero", F3_DIVU, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1, 0);
        run_op("rem_zero",  F3_REM,  32'h1234_5678, 32'h0, 32'h1234_5678, 1, 0);
        run_op("div_ovf",   F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem_ovf",   F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

        // back-to-back with Start held high
        run_op("b2b_mul", F3_MUL, 32'd6, 32'd7, 32'd42, 2, 1);
        run_op("b2b_div", F3_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, 0);

        // random operations against the reference model
        for (int i = 0; i < 8; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom);
            if (i == 0) rb = 32'd1;
            run_op("random", rf3, ra, rb, ref_result(rf3, ra, rb),
                   ref_latency(rf3, ra, rb), 0);
        end

        // leave a known non-zero Result, then reset in the middle of a divide
        run_op("pre_reset", F3_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
        @(negedge CPU_clk);
        Start    = 1'b1;
        Funct3   = F3_DIVU;
        OperandA = 32'd1000;
        OperandB = 32'd3;
        @(negedge CPU_clk);
        Start = 1'b0;
        repeat (9) @(negedge CPU_clk);
        CPU_rst_n = 1'b0;
        #1;
        check("midreset_result", Result, 32'h0);
        check("midreset_done", 32'(Done), 32'd0);
        check("midreset_busy", 32'(Busy), 32'd0);
        check("midreset_state", 32'(dbg_state), 32'(IDLE));
        @(negedge CPU_clk);
        CPU_rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge CPU_clk);
            #1;
            if (Done) done_seen++;
        end
        check("midreset_no_done", 32'(done_seen), 32'd0);
        run_op("post_reset", F3_REMU, 32'd1000, 32'd3, 32'd1, 33, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
